booth_r4_mul: RTL and testbench
===============================

Name: booth_r4_mul

Overview:
- Parametrised radix-4 (modified) Booth sequential multiplier. Successor to the team's 16-bit radix-2 Booth unit.
- Adds width generalisation, a per-operation signed/unsigned mode, a one-cycle done pulse, and about half the iteration count.
- Sits in the datapath as a shared multi-cycle multiply resource, driven by a start/busy/done handshake from the controlling FSM.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and >= 4; violations are an elaboration-time error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- x  in  WIDTH  multiplicand; sampled with start.
- y  in  WIDTH  multiplier; sampled with start.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- z  out  2*WIDTH  product; holds the last completed result.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; z is valid in this cycle.

Behaviour:
- Reset:
  - rst=1 at a rising edge sets z=0, busy=0, done=0, state IDLE, and clears the counter and internal registers.
  - rst takes priority over start and over any in-flight operation.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CALC, FIN.
  - IDLE: start=1 latches x, y and is_signed, then goes to CALC. busy goes to 1 from the next cycle.
  - CALC: performs one radix-4 step per cycle for N = WIDTH/2 + 1 cycles, then goes to FIN.
  - FIN: one cycle. busy=0, done=1, z updated. Returns to IDLE.
- Timing: start sampled in cycle T. busy=1 in cycles T+1 .. T+N. done=1 and the new z appear in cycle T+N+1.
  - WIDTH=16 gives 9 CALC cycles, with done in T+10.
- start in FIN is accepted: FIN behaves as IDLE for acceptance, so back-to-back operations have one idle-free cycle.
- start while busy=1 (CALC) is ignored entirely; latched operands are unaffected.
- Operand extension:
  - x and y are extended to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when is_signed=0.
  - The extended multiplier gets an implicit 0 appended below its LSB (the y[-1] bit).
- Recoding: each CALC step examines the multiplier triplet {y[i+1], y[i], y[i-1]}.
  - 000 or 111 -> 0.
  - 001 or 010 -> +X.
  - 011 -> +2X.
  - 100 -> -2X.
  - 101 or 110 -> -X.
- Accumulator: the partial product is added to the upper WIDTH+3 bits of the accumulator.
  - The accumulator is then arithmetically shifted right by 2.
  - The multiplier register is shifted right by 2.
- Width rules:
  - Partial-product adder is WIDTH+3 bits, so ±2X never overflows.
  - -X is formed as bitwise inverse of extended X plus 1 inside the extended width. The most-negative signed operand is exact.
- Result: z = low 2*WIDTH bits of the final accumulator. This is the exact signed or unsigned product.
- z changes only in FIN or on reset; it is stable at all other times.
- Input changes on x, y or is_signed while busy have no effect.

Test Plan:
- WIDTH=16, is_signed=1, x=0xFFFD (-3), y=0x0005 -> z=0xFFFFFFF1 (-15). done in cycle T+10. busy high in T+1..T+9.
- WIDTH=16, is_signed=1, x=y=0x8000 -> z=0x40000000. With is_signed=0 and the same operands -> z=0x40000000. Also x=y=0xFFFF unsigned -> z=0xFFFE0001; signed -> z=0x00000001.
- Mid-operation start: start with x=7, y=9; at T+4 pulse start with x=2, y=2 -> ignored; done at T+10 with z=63. A new start issued in the FIN cycle with x=2, y=2 -> done 10 cycles later with z=4.
- Reset mid-op: start with x=100, y=100; assert rst at T+5 -> z=0, busy=0, done=0 next cycle and no done pulse afterwards. A following start of 3*4 -> z=12.
- WIDTH=8 instance, randomised: 1000 random (x, y, is_signed) triples compared against a reference product. 5 CALC cycles each. Corners 0x80*0x80 signed=0x4000, unsigned 0xFF*0xFF=0xFE01.
- Idle hold: no start for 50 cycles after a result -> z unchanged, done stays 0, busy stays 0.

Source files
------------

// File: rtl/booth_r4_mul_if.sv
`default_nettype none
// ------------------------------------------------------------------
// booth_r4_mul_if : start/busy/done handshake and operand/product bus
// Revision 1.0
// ------------------------------------------------------------------
interface booth_r4_mul_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               is_signed;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               done;

  modport master (
    output start, x, y, is_signed,
    input  z, busy, done
  );

  modport slave (
    input  start, x, y, is_signed,
    output z, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/booth_r4_mul.sv
`default_nettype none
// ------------------------------------------------------------------
// booth_r4_mul : sequential radix-4 Booth multiplier, signed/unsigned
// Revision 1.0
// ------------------------------------------------------------------
module booth_r4_mul #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  booth_r4_mul_if.slave bus
);

  localparam int PW = WIDTH + 3;
  localparam int AW = 2 * WIDTH + 5;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_r4_mul: WIDTH must be even and >= 4");
    end
  endgenerate

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [PW-1:0]      xe;
  logic [PW-1:0]      mr;
  logic [AW-1:0]      acc;
  logic [2*WIDTH-1:0] prod;

  logic [PW-1:0]      pp;
  logic [PW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic               last;

  // Booth digit from the low triplet of the shifting multiplier register
  always_comb begin
    pp = '0;
    case (mr[2:0])
      3'b001, 3'b010: pp = xe;
      3'b011:         pp = xe << 1;
      3'b100:         pp = ~(xe << 1) + 1'b1;
      3'b101, 3'b110: pp = ~xe + 1'b1;
      default:        pp = '0;
    endcase
  end

  assign sum     = acc[AW-1 -: PW] + pp;
  assign acc_nxt = $signed({sum, acc[WIDTH+1:0]}) >>> 2;
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      xe    <= '0;
      mr    <= '0;
      acc   <= '0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (bus.start) begin
            xe    <= {{3{bus.is_signed & bus.x[WIDTH-1]}}, bus.x};
            mr    <= {{2{bus.is_signed & bus.y[WIDTH-1]}}, bus.y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          mr  <= mr >> 2;
          cnt <= cnt + 1'b1;
          if (last) begin
            prod  <= acc_nxt[2*WIDTH-1:0];
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.z    = prod;
  assign bus.busy = (state == CALC);
  assign bus.done = (state == FIN);

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mul.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_booth_r4_mul : directed + random scoreboard bench, WIDTH=16 and 8
// Revision 1.0
// ------------------------------------------------------------------
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_r4_mul_if #(.WIDTH(16)) b16();
  booth_r4_mul_if #(.WIDTH(8))  b8();

  booth_r4_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  booth_r4_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int tests = 0;
  int fails = 0;
  logic [31:0] q16[$];
  logic [15:0] q8[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa;
    int pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  // Drives start for one cycle; returns in cycle T+1 with operands scrambled
  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] exp, input bit push);
    b16.x = a; b16.y = b; b16.is_signed = s; b16.start = 1'b1;
    if (push) q16.push_back(exp);
    step();
    b16.start = 1'b0;
    b16.x = 16'($urandom); b16.y = 16'($urandom); b16.is_signed = 1'($urandom);
  endtask

  // Entered in cycle T+1; returns in the FIN cycle T+10
  task automatic collect16(input string tag, input int inject_at);
    int bad;
    logic [31:0] zprev;
    bad = 0;
    zprev = b16.z;
    for (int k = 1; k <= 9; k++) begin
      if (b16.busy !== 1'b1 || b16.done !== 1'b0 || b16.z !== zprev) bad++;
      if (k == inject_at) begin
        b16.start = 1'b1; b16.x = 16'd2; b16.y = 16'd2; b16.is_signed = 1'b0;
      end else begin
        b16.start = 1'b0;
      end
      step();
    end
    b16.start = 1'b0;
    check({tag, "_busy_window"}, bad, 0);
    check({tag, "_done"}, {31'b0, b16.done}, 32'd1);
    check({tag, "_busy_fin"}, {31'b0, b16.busy}, 32'd0);
    check({tag, "_queue"}, q16.size(), 1);
    if (q16.size() != 0) check({tag, "_z"}, b16.z, q16.pop_front());
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp);
    b8.x = a; b8.y = b; b8.is_signed = s; b8.start = 1'b1;
    q8.push_back(exp);
    step();
    b8.start = 1'b0;
    b8.x = 8'($urandom); b8.y = 8'($urandom); b8.is_signed = 1'($urandom);
  endtask

  task automatic collect8(input string tag);
    int bad;
    logic [15:0] zprev;
    bad = 0;
    zprev = b8.z;
    for (int k = 1; k <= 5; k++) begin
      if (b8.busy !== 1'b1 || b8.done !== 1'b0 || b8.z !== zprev) bad++;
      step();
    end
    check({tag, "_busy_window"}, bad, 0);
    check({tag, "_done"}, {31'b0, b8.done}, 32'd1);
    check({tag, "_queue"}, q8.size(), 1);
    if (q8.size() != 0) check({tag, "_z"}, {16'b0, b8.z}, {16'b0, q8.pop_front()});
  endtask

  initial begin
    int cnt;
    logic [31:0] zh;
    logic [7:0] ra, rb;
    logic rs;

    rst = 1'b1;
    b16.start = 1'b0; b16.x = '0; b16.y = '0; b16.is_signed = 1'b0;
    b8.start  = 1'b0; b8.x  = '0; b8.y  = '0; b8.is_signed  = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_z16", b16.z, 32'd0);
    check("rst_busy16", {31'b0, b16.busy}, 32'd0);
    check("rst_done16", {31'b0, b16.done}, 32'd0);
    check("rst_z8", {16'b0, b8.z}, 32'd0);
    check("rst_busy8", {31'b0, b8.busy}, 32'd0);

    launch16(16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1, 1'b1);
    collect16("neg3x5", 0);
    step();
    check("done_pulse_width", {31'b0, b16.done}, 32'd0);
    check("z_hold_after_fin", b16.z, 32'hFFFF_FFF1);

    launch16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1); collect16("min_min_s", 0); step();
    launch16(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 1'b1); collect16("min_min_u", 0); step();
    launch16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1); collect16("ffff_u", 0); step();
    launch16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b1); collect16("ffff_s", 0); step();

    // start during CALC must be ignored; start during FIN must be accepted
    launch16(16'd7, 16'd9, 1'b0, 32'd63, 1'b1);
    collect16("mid_start", 4);
    launch16(16'd2, 16'd2, 1'b0, 32'd4, 1'b1);
    collect16("fin_start", 0);
    step();

    launch16(16'd100, 16'd100, 1'b0, 32'd10000, 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_z", b16.z, 32'd0);
    check("abort_busy", {31'b0, b16.busy}, 32'd0);
    check("abort_done", {31'b0, b16.done}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (b16.done !== 1'b0 || b16.busy !== 1'b0) cnt++;
      step();
    end
    check("abort_quiet", cnt, 0);
    launch16(16'd3, 16'd4, 1'b0, 32'd12, 1'b1);
    collect16("after_abort", 0);
    step();

    zh = b16.z;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (b16.z !== zh || b16.done !== 1'b0 || b16.busy !== 1'b0) cnt++;
      step();
    end
    check("idle_hold", cnt, 0);
    check("idle_hold_z", b16.z, 32'd12);

    launch8(8'h80, 8'h80, 1'b1, 16'h4000); collect8("w8_min_s"); step();
    launch8(8'hFF, 8'hFF, 1'b0, 16'hFE01); collect8("w8_ff_u"); step();

    // back-to-back random run: each launch lands in the previous FIN cycle
    ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
    launch8(ra, rb, rs, ref8(ra, rb, rs));
    for (int i = 0; i < 1000; i++) begin
      collect8("w8_rand");
      if (i < 999) begin
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        launch8(ra, rb, rs, ref8(ra, rb, rs));
      end
    end
    step();
    check("w8_done_low", {31'b0, b8.done}, 32'd0);
    check("w8_busy_low", {31'b0, b8.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
